// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   - op_e: operation encoding driven by the instruction decoder.
//   - STACK_WRAP: compile-time selection of the return-stack full behaviour.
//     Controlled by the macro PC_SEQ_STACK_WRAP_EN. When it is defined, a CALL
//     on a full stack overwrites the oldest entry. Otherwise that CALL is
//     refused and the ovf flag is raised.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_BRC  = 3'd2,
    OP_JMP  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

`ifdef PC_SEQ_STACK_WRAP_EN
  localparam bit STACK_WRAP = 1'b1;
`else
  localparam bit STACK_WRAP = 1'b0;
`endif

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: return-address LIFO for the PC sequencer.
//
// The storage is a shift stack. Entry 0 is always the top of the stack.
// A push shifts every entry one place deeper, and a pop shifts every entry one
// place shallower. With this layout a wrapping push on a full stack discards
// the oldest entry without any extra pointer logic.
// The wrap behaviour follows pc_seq_pkg::STACK_WRAP, which is controlled by the
// macro PC_SEQ_STACK_WRAP_EN.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_i        push push_data_i. Ignored when the stack is full, unless wrap is enabled.
//   push_data_i   address to push
//   pop_i         pop the top entry. Ignored when the stack is empty.
//                 push_i has priority if both are asserted.
//   top_o         current top entry (this value is don't-care when the stack is empty)
//   depth_o       number of valid entries
//   full_o        depth_o == DEPTH
//   empty_o       depth_o == 0
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] top_o,
  output logic [DW-1:0]    depth_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;

  assign full_o  = (depth_q == DEPTH_MAX);
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;
  assign top_o   = mem_q[0];

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push_i && (STACK_WRAP || !full_o)) begin
      for (int i = DEPTH - 1; i > 0; i--) mem_d[i] = mem_q[i-1];
      mem_d[0] = push_data_i;
      // A wrapping push on a full stack keeps the depth at DEPTH.
      if (!full_o) depth_d = depth_q + DW'(1);
    end else if (pop_i && !empty_o) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      depth_q <= depth_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer. It sits between the instruction
// decoder and the instruction memory.
//
// Supported operations: hold, increment, conditional relative branch, absolute
// jump, and call/return through an internal return-address stack.
// All PC arithmetic wraps modulo 2^WIDTH. The pc output comes straight from a
// register, so the inputs have no combinational path to pc.
// Optional build macro: PC_SEQ_STACK_WRAP_EN. When it is defined, the return
// stack is circular and ovf is tied to 0.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en         update enable for pc, stack and depth
//   op         operation code (pc_seq_pkg::op_e encoding)
//   operand    branch offset (two's complement) or absolute target
//   cond       branch condition used by BRC
//   err_clr    clears the sticky flags. It works independently of en, and a
//              new error in the same cycle wins.
//   pc         current program counter
//   depth      number of valid return-stack entries
//   ovf        sticky flag: CALL attempted while the stack was full
//   unf        sticky flag: RET attempted while the stack was empty
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH     = 6,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           operand,
  input  logic                       cond,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       ovf,
  output logic                       unf
);

  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovf_set, unf_set;
  logic             push, pop;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] stk_top;
  logic             stk_full, stk_empty;

  assign pc_inc = pc_q + WIDTH'(1);

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (pc_inc),
    .pop_i       (pop),
    .top_o       (stk_top),
    .depth_o     (depth),
    .full_o      (stk_full),
    .empty_o     (stk_empty)
  );

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (en) begin
      case (op_e'(op))
        OP_INC: pc_d = pc_inc;
        // Sign-agnostic modulo add: a negative offset simply wraps.
        OP_BRC: pc_d = cond ? (pc_inc + operand) : pc_inc;
        OP_JMP: pc_d = operand;
        OP_CALL: begin
          if (!stk_full || STACK_WRAP) begin
            push = 1'b1;
            pc_d = operand;
          end else begin
            ovf_set = 1'b1;
          end
        end
        OP_RET: begin
          if (!stk_empty) begin
            pop  = 1'b1;
            pc_d = stk_top;
          end else begin
            unf_set = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
    // A new error in the same cycle as err_clr leaves the flag set.
    ovf_d = (ovf_q & ~err_clr) | ovf_set;
    unf_d = (unf_q & ~err_clr) | unf_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc  = pc_q;
  assign ovf = STACK_WRAP ? 1'b0 : ovf_q;
  assign unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test of pc_sequencer with WIDTH=6, DEPTH=4 and
// RESET_VEC=0. The expected values below were worked out by hand. The overflow
// scenario selects its expected values according to PC_SEQ_STACK_WRAP_EN.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] op = 3'd0;
  logic [5:0] operand = 6'd0;
  logic       cond = 1'b0;
  logic       err_clr = 1'b0;
  logic [5:0] pc;
  logic [2:0] depth;
  logic       ovf, unf;

  int n_pass = 0;
  int n_total = 0;

  pc_sequencer #(.WIDTH(6), .DEPTH(4), .RESET_VEC(6'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .operand(operand), .cond(cond),
    .err_clr(err_clr), .pc(pc), .depth(depth), .ovf(ovf), .unf(unf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Inputs are driven at the negedge. Results are sampled 1 time unit after the
  // posedge. en and err_clr are then dropped so that nothing else changes.
  task automatic step(input logic e, input logic [2:0] o, input logic [5:0] opnd,
                      input logic c, input logic clr);
    @(negedge clk);
    en = e; op = o; operand = opnd; cond = c; err_clr = clr;
    @(posedge clk);
    #1;
    en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++; if (pc !== 6'd0) $display("FAIL reset_pc got %0d exp 0", pc); else n_pass++;
    n_total++; if (depth !== 3'd0) $display("FAIL reset_depth got %0d exp 0", depth); else n_pass++;
    n_total++; if ({ovf, unf} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {ovf, unf}); else n_pass++;
  endtask

  task automatic test_inc();
    logic [5:0] exp_pc [3];
    exp_pc[0] = 6'd1; exp_pc[1] = 6'd2; exp_pc[2] = 6'd3;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd1, 6'd0, 1'b0, 1'b0);
      n_total++; if (pc !== exp_pc[i]) $display("FAIL inc%0d got %0d exp %0d", i, pc, exp_pc[i]); else n_pass++;
    end
    step(1'b0, 3'd1, 6'd0, 1'b0, 1'b0);
    n_total++; if (pc !== 6'd3) $display("FAIL hold_en0 got %0d exp 3", pc); else n_pass++;
    step(1'b1, 3'd7, 6'd9, 1'b1, 1'b0);
    n_total++; if (pc !== 6'd3) $display("FAIL reserved_op got %0d exp 3", pc); else n_pass++;
  endtask

  task automatic test_brc();
    step(1'b1, 3'd3, 6'd10, 1'b0, 1'b0);
    n_total++; if (pc !== 6'd10) $display("FAIL jmp10 got %0d exp 10", pc); else n_pass++;
    step(1'b1, 3'd2, 6'h3E, 1'b1, 1'b0);
    n_total++; if (pc !== 6'd9) $display("FAIL brc_taken got %0d exp 9", pc); else n_pass++;
    step(1'b1, 3'd3, 6'd10, 1'b0, 1'b0);
    step(1'b1, 3'd2, 6'h3E, 1'b0, 1'b0);
    n_total++; if (pc !== 6'd11) $display("FAIL brc_not_taken got %0d exp 11", pc); else n_pass++;
    step(1'b1, 3'd3, 6'd63, 1'b0, 1'b0);
    step(1'b1, 3'd1, 6'd0, 1'b0, 1'b0);
    n_total++; if (pc !== 6'd0) $display("FAIL inc_wrap got %0d exp 0", pc); else n_pass++;
  endtask

  task automatic test_call_ret();
    logic [2:0] o_v [4];
    logic [5:0] a_v [4];
    logic [5:0] pc_v [4];
    logic [2:0] d_v [4];
    o_v[0] = 3'd4; a_v[0] = 6'd20; pc_v[0] = 6'd20; d_v[0] = 3'd1;
    o_v[1] = 3'd4; a_v[1] = 6'd30; pc_v[1] = 6'd30; d_v[1] = 3'd2;
    o_v[2] = 3'd5; a_v[2] = 6'd0;  pc_v[2] = 6'd21; d_v[2] = 3'd1;
    o_v[3] = 3'd5; a_v[3] = 6'd0;  pc_v[3] = 6'd6;  d_v[3] = 3'd0;
    step(1'b1, 3'd3, 6'd5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, o_v[i], a_v[i], 1'b0, 1'b0);
      n_total++; if (pc !== pc_v[i]) $display("FAIL callret_pc%0d got %0d exp %0d", i, pc, pc_v[i]); else n_pass++;
      n_total++; if (depth !== d_v[i]) $display("FAIL callret_depth%0d got %0d exp %0d", i, depth, d_v[i]); else n_pass++;
    end
    // Return address wrap: pc=63 pushes 0.
    step(1'b1, 3'd3, 6'd63, 1'b0, 1'b0);
    step(1'b1, 3'd4, 6'd7, 1'b0, 1'b0);
    step(1'b1, 3'd5, 6'd0, 1'b0, 1'b0);
    n_total++; if (pc !== 6'd0) $display("FAIL ret_addr_wrap got %0d exp 0", pc); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [5:0] exp_ret [4];
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 3'd4, 6'd8, 1'b0, 1'b0);
    n_total++; if (depth !== 3'd4) $display("FAIL full_depth got %0d exp 4", depth); else n_pass++;
    step(1'b1, 3'd4, 6'd8, 1'b0, 1'b0);
    n_total++; if (pc !== 6'd8) $display("FAIL ovf_pc got %0d exp 8", pc); else n_pass++;
    n_total++; if (depth !== 3'd4) $display("FAIL ovf_depth got %0d exp 4", depth); else n_pass++;
`ifdef PC_SEQ_STACK_WRAP_EN
    n_total++; if (ovf !== 1'b0) $display("FAIL ovf_flag got %b exp 0", ovf); else n_pass++;
    exp_ret[0] = 6'd9; exp_ret[1] = 6'd9; exp_ret[2] = 6'd9; exp_ret[3] = 6'd9;
`else
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_flag got %b exp 1", ovf); else n_pass++;
    exp_ret[0] = 6'd9; exp_ret[1] = 6'd9; exp_ret[2] = 6'd9; exp_ret[3] = 6'd1;
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd5, 6'd0, 1'b0, 1'b0);
      n_total++; if (pc !== exp_ret[i]) $display("FAIL ovf_ret%0d got %0d exp %0d", i, pc, exp_ret[i]); else n_pass++;
    end
    n_total++; if (depth !== 3'd0) $display("FAIL ovf_drained got %0d exp 0", depth); else n_pass++;
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b1, 3'd3, 6'd12, 1'b0, 1'b0);
    step(1'b1, 3'd5, 6'd0, 1'b0, 1'b0);
    n_total++; if (pc !== 6'd12) $display("FAIL unf_pc got %0d exp 12", pc); else n_pass++;
    n_total++; if (unf !== 1'b1) $display("FAIL unf_set got %b exp 1", unf); else n_pass++;
    n_total++; if (depth !== 3'd0) $display("FAIL unf_depth got %0d exp 0", depth); else n_pass++;
    step(1'b1, 3'd5, 6'd0, 1'b0, 1'b1);
    n_total++; if (unf !== 1'b1) $display("FAIL unf_clr_collide got %b exp 1", unf); else n_pass++;
    step(1'b1, 3'd1, 6'd0, 1'b0, 1'b0);
    n_total++; if (unf !== 1'b1) $display("FAIL unf_sticky got %b exp 1", unf); else n_pass++;
    step(1'b0, 3'd0, 6'd0, 1'b0, 1'b1);
    n_total++; if (unf !== 1'b0) $display("FAIL unf_clr got %b exp 0", unf); else n_pass++;
    n_total++; if (pc !== 6'd13) $display("FAIL unf_clr_pc got %0d exp 13", pc); else n_pass++;
  endtask

  task automatic test_async_reset();
    step(1'b1, 3'd5, 6'd0, 1'b0, 1'b0);
    step(1'b1, 3'd4, 6'd40, 1'b0, 1'b0);
    step(1'b1, 3'd4, 6'd50, 1'b0, 1'b0);
    n_total++; if (depth !== 3'd2 || unf !== 1'b1 || pc !== 6'd50)
      $display("FAIL pre_reset got pc=%0d depth=%0d unf=%b exp pc=50 depth=2 unf=1", pc, depth, unf);
    else n_pass++;
    // Assert reset mid-cycle, between edges, with a CALL pending.
    @(negedge clk);
    en = 1'b1; op = 3'd4; operand = 6'd33;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (pc !== 6'd0) $display("FAIL async_pc got %0d exp 0", pc); else n_pass++;
    n_total++; if (depth !== 3'd0) $display("FAIL async_depth got %0d exp 0", depth); else n_pass++;
    n_total++; if ({ovf, unf} !== 2'b00) $display("FAIL async_flags got %b exp 00", {ovf, unf}); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (pc !== 6'd0) $display("FAIL async_hold_pc got %0d exp 0", pc); else n_pass++;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_inc();
    test_brc();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer; next generation of the 6-bit increment/relative-branch PC.
- Holds the PC internally and adds absolute jump, conditional relative branch, and call/return through an on-chip return-address stack.
- Sits between the instruction decoder (supplies op/operand/cond) and instruction memory (consumes pc).

Parameters:
- WIDTH, 6, PC and operand width in bits; all PC arithmetic is modulo 2^WIDTH.
- DEPTH, 4, return-stack entries; DEPTH >= 1.
- RESET_VEC, 0, PC value loaded on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  update enable; when 0, pc, stack and depth hold.
- op  input  3  operation code, sampled when en=1.
- operand  input  WIDTH  branch offset (two's complement) or absolute target.
- cond  input  1  branch condition for BRC.
- err_clr  input  1  clears sticky error flags; acts regardless of en.
- pc  output  WIDTH  current program counter (registered).
- depth  output  $clog2(DEPTH+1)  current number of valid stack entries.
- ovf  output  1  sticky flag: CALL attempted with the stack full.
- unf  output  1  sticky flag: RET attempted with the stack empty.

Behaviour:
- Reset (asynchronous, immediate on rst=1): pc=RESET_VEC, depth=0, ovf=0, unf=0. Stack contents are don't-care.
- Reset asserted mid-operation aborts any update in that cycle.
- All state updates on the posedge where en=1. Single-cycle latency: the new pc is visible after that edge. No combinational path from inputs to pc.
- Op 0 HOLD: no change.
- Op 1 INC: pc <= pc+1.
- Op 2 BRC:
  - cond=1: pc <= pc+1+operand (wraps, sign-agnostic modulo add).
  - cond=0: pc <= pc+1.
- Op 3 JMP: pc <= operand.
- Op 4 CALL:
  - depth<DEPTH: push pc+1, depth+1, pc <= operand.
  - depth=DEPTH: see Optional Feature.
- Op 5 RET:
  - depth>0: pc <= top entry, depth-1.
  - depth=0: pc held, depth held, unf <= 1.
- Ops 6, 7: reserved; behave as HOLD.
- Return address pc+1 wraps, e.g. WIDTH=6, pc=63 pushes 0.
- Sticky flags:
  - Set only by their error event; cleared by err_clr=1 at the posedge.
  - err_clr and a new error in the same cycle: the flag ends set.
  - Flags never self-clear.
- The stack is strictly LIFO; only one push or pop per cycle (ops are exclusive).

Optional Feature:
- Macro: PC_SEQ_STACK_WRAP_EN.
- Defined: CALL with depth=DEPTH overwrites the oldest entry (circular stack). Jump is performed, depth stays DEPTH, ovf is never set (tied 0). Later RETs return the DEPTH most recent addresses.
- Undefined: CALL with depth=DEPTH leaves pc, stack and depth unchanged and sets ovf.

Decomposition:
- Package pc_seq_pkg: op encoding constants/enum (OP_HOLD=0, OP_INC=1, OP_BRC=2, OP_JMP=3, OP_CALL=4, OP_RET=5).
- Sub-module pc_ret_stack: parametrised LIFO (WIDTH, DEPTH) with push, pop, top, depth, full, empty, and the wrap option.
- pc_sequencer holds next-pc mux, PC register and error flags.

Test Plan (WIDTH=6, DEPTH=4, RESET_VEC=0):
- Reset then 3x INC -> pc=0,1,2,3; HOLD with en=0 -> pc stays 3.
- pc=10, BRC operand=6'h3E (-2), cond=1 -> pc=9; same with cond=0 -> pc=11; pc=63 INC -> 0.
- CALL 20, CALL 30, RET, RET starting from pc=5 -> pc=20, 30, 21, 6; depth 1,2,1,0.
- 5 CALLs to 8 from pc=0. Without macro: fifth call holds pc, ovf=1, depth=4. With macro: pc=8, ovf=0, then 4 RETs return to 9,9,9,9 (oldest entry lost).
- RET at depth=0 -> pc unchanged, unf=1; err_clr together with a second empty RET -> unf remains 1; err_clr alone -> unf=0.
- Assert rst asynchronously mid-cycle after CALLs -> pc=0, depth=0, flags 0 immediately, before the next clock edge.
